// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative unsigned restoring divider. A left-shifting
//               remainder:quotient register pair produces one quotient bit
//               per clock; a divide-by-zero request completes immediately.
// Ports       : Clk          - system clock, rising edge
//               reset        - synchronous active-high reset
//               start        - request a division (sampled in IDLE only)
//               dividend     - unsigned dividend, captured on acceptance
//               divisor      - unsigned divisor, captured on acceptance
//               busy         - high while the iteration is running
//               done         - high while the result is being presented
//               div_by_zero  - flag of the last completed operation
//               quotient     - registered quotient of last completion
//               remainder    - registered remainder of last completion
// Options     : SEQ_DIVIDER_HOLD_EN - when defined, DONE is held until start
//               is sampled low, so a held start yields a single division.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH:0]   w_a_step;
    logic [WIDTH-1:0] w_q_step;
    logic             w_unused_a_msb;

    // One restoring step: shift the pair left, try subtracting the divisor,
    // keep the difference only when it did not go negative.
    assign w_shift  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, d_q};
    assign w_fits   = ~w_trial[WIDTH];
    assign w_a_step = w_fits ? w_trial : w_shift;
    assign w_q_step = (q_q << 1) | WIDTH'(w_fits);

    // The partial remainder always stays below the divisor, so A's top bit
    // is never needed by the next shift.
    assign w_unused_a_msb = a_q[WIDTH];

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        a_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                a_d   = w_a_step;
                q_d   = w_q_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    quot_d  = w_q_step;
                    rem_d   = w_a_step[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef SEQ_DIVIDER_HOLD_EN
                if (!start) begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider. Stimulus pushes expected
//               results; a monitor pops and compares on each rising done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         busy_len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .Clk         (clk),
        .reset       (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares each completion against the scoreboard head.
    initial begin : monitor
        logic done_prev;
        int   busy_run;
        exp_t e;
        done_prev = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
                busy_run  = 0;
            end else begin
                if (busy && done) chk("busy_and_done", 1, 0);
                if (busy) busy_run++;
                if (done && !done_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("quotient",    int'(quotient),    int'(e.q));
                        chk("remainder",   int'(remainder),   int'(e.r));
                        chk("div_by_zero", int'(div_by_zero), int'(e.z));
                        chk("busy_cycles", busy_run,          e.busy_len);
                        if (!e.z)
                            chk("invariant",
                                (int'(quotient) * int'(e.b) + int'(remainder) == int'(e.a))
                                && (remainder < e.b) ? 1 : 0, 1);
                    end
                    busy_run = 0;
                end
                done_prev = done;
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.z = 1'b1; e.busy_len = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0; e.busy_len = WIDTH;
        end
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b);
        push(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    initial begin : stim
        int n;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem",  int'(remainder), 0);
        chk("rst_dbz",  int'(div_by_zero), 0);
        rst = 1'b0;

        // Basic and edge values
        run(8'd200, 8'd7);
        run(8'd255, 8'd1);
        run(8'd5,   8'd9);
        run(8'd0,   8'd3);
        run(8'd255, 8'd255);

        // Divide by zero, then a normal one clears the flag
        run(8'd77, 8'd0);
        run(8'd9,  8'd2);

        // Reset at CALC step 4 aborts without a result
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quot", int'(quotient), 0);
        chk("midrst_rem",  int'(remainder), 0);
        chk("midrst_dbz",  int'(div_by_zero), 0);
        repeat (12) @(negedge clk);
        run(8'd100, 8'd3);

        // Start pulse during CALC is ignored
        push(8'd50, 8'd5);
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd9; divisor = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Held start
`ifdef SEQ_DIVIDER_HOLD_EN
        push(8'd60, 8'd7);
        @(negedge clk);
        dividend = 8'd60; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        wait_done();
        repeat (5) begin
            @(negedge clk);
            chk("hold_done_high", int'(done), 1);
            chk("hold_busy_low",  int'(busy), 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold_release_done", int'(done), 0);
        @(negedge clk);
        chk("hold_no_restart", int'(busy), 0);
`else
        repeat (3) push(8'd60, 8'd7);
        @(negedge clk);
        dividend = 8'd60; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        wait_done();
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            chk("held_period", n, WIDTH + 2);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("held_stop", int'(busy), 0);
`endif

        // Random sweep
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run(ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
